alu_regfile: RTL

Register file for the single-cycle datapath, sitting directly upstream of the ALU: two combinational read ports drive the ALU A and B operands, and one synchronous write port takes the write-back result. The ALU Overflow flag is an input to the write port. An overflowing write is suppressed and recorded in a sticky trap status, which gives signed add/sub their trap-on-overflow behaviour without extra datapath logic.

---
 rtl/alu_regfile.sv | 103 ++++++++++
 1 files changed

// File: rtl/alu_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_regfile                                                |
// | Description : Two-read / one-write register file feeding the ALU.        |
// |               Writes flagged with ALU overflow are suppressed and logged |
// |               in a sticky trap status (flag, address, saturating count). |
// | Option      : ALU_REGFILE_BYPASS_EN - same-cycle write-to-read forwarding|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_regfile #(
   parameter int N          = 32,
   parameter int DEPTH_LOG2 = 5,
   parameter int OVF_CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DEPTH_LOG2-1:0] ra1,
   input  logic [DEPTH_LOG2-1:0] ra2,
   output logic [N-1:0]          rd1,
   output logic [N-1:0]          rd2,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] wa,
   input  logic [N-1:0]          wd,
   input  logic                  wr_ovf,
   input  logic                  ovf_clr,
   output logic                  ovf_flag,
   output logic [DEPTH_LOG2-1:0] ovf_addr,
   output logic [OVF_CNT_W-1:0]  ovf_cnt
);

   localparam int                   c_DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [OVF_CNT_W-1:0] c_CNT_MAX = '1;
   localparam logic [OVF_CNT_W-1:0] c_CNT_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

   logic [N-1:0]          r_mem [c_DEPTH];
   logic                  r_ovf_flag;
   logic [DEPTH_LOG2-1:0] r_ovf_addr;
   logic [OVF_CNT_W-1:0]  r_ovf_cnt;

   logic                  w_commit;
   logic                  w_trap;
   logic [N-1:0]          w_rd1;
   logic [N-1:0]          w_rd2;

   // A trap is seen even for register 0; a commit never targets register 0.
   assign w_trap   = we && wr_ovf;
   assign w_commit = we && !wr_ovf && (wa != '0);

   // Storage array: cleared on reset, written only on a clean commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_commit) begin
         r_mem[wa] <= wd;
      end
   end

   // Combinational read ports; register 0 is hard-wired to zero.
   always_comb begin
      w_rd1 = (ra1 == '0) ? '0 : r_mem[ra1];
      w_rd2 = (ra2 == '0) ? '0 : r_mem[ra2];
`ifdef ALU_REGFILE_BYPASS_EN
      // Forward only committing writes, so traps and r0 never leak through.
      if (w_commit && (wa == ra1)) begin
         w_rd1 = wd;
      end
      if (w_commit && (wa == ra2)) begin
         w_rd2 = wd;
      end
`endif
   end

   // Sticky trap status; a trap in the same cycle as a clear takes priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf_flag <= 1'b0;
         r_ovf_addr <= '0;
         r_ovf_cnt  <= '0;
      end else if (w_trap) begin
         r_ovf_flag <= 1'b1;
         r_ovf_addr <= wa;
         if (ovf_clr) begin
            r_ovf_cnt <= c_CNT_ONE;
         end else if (r_ovf_cnt != c_CNT_MAX) begin
            r_ovf_cnt <= r_ovf_cnt + c_CNT_ONE;
         end
      end else if (ovf_clr) begin
         r_ovf_flag <= 1'b0;
         r_ovf_addr <= '0;
         r_ovf_cnt  <= '0;
      end
   end

   assign rd1      = w_rd1;
   assign rd2      = w_rd2;
   assign ovf_flag = r_ovf_flag;
   assign ovf_addr = r_ovf_addr;
   assign ovf_cnt  = r_ovf_cnt;

endmodule
`default_nettype wire
